// File: rtl/aq_vfalu_pkg.sv
// Shared vfalu definitions: rounding-mode encodings, fflag bit positions and half-format widths.
// Also holds the captured-operand record passed from the capture stage to the round/pack stage.
package aq_vfalu_pkg;

    localparam int HALF_EXP_W = 5;
    localparam int HALF_MAN_W = 10;
    localparam int HLEN       = 1 + HALF_EXP_W + HALF_MAN_W;
    localparam int FX_W       = 54;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;

    typedef struct packed {
        logic                  sign;
        logic [2:0]            rm;
        logic [HALF_MAN_W-1:0] man;
        logic                  guard;
        logic                  sticky;
        logic                  special;
        logic [HLEN-1:0]       spec_res;
        logic [4:0]            spec_ff;
    } xtoh_s1_t;

endpackage

// File: rtl/aq_fcnvt_xtoh_rnd_inc.sv
// Round-increment decision from rounding mode, sign, kept lsb, guard and sticky.
// Purely combinational so the normal-number path can share it.
module aq_fcnvt_xtoh_rnd_inc
    import aq_vfalu_pkg::*;
(
    input  logic [2:0] rm,
    input  logic       sign,
    input  logic       lsb,
    input  logic       guard,
    input  logic       sticky,
    output logic       inc
);

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        inc = 1'b0;
        case (rm)
            RM_RNE:  inc = guard & (sticky | lsb);
            RM_RDN:  inc = sign & (guard | sticky);
            RM_RUP:  inc = ~sign & (guard | sticky);
            RM_RMM:  inc = guard;
            default: inc = 1'b0; // RTZ and the reserved encodings truncate
        endcase
    end

endmodule

// File: rtl/aq_fcnvt_xtoh_rnd.sv
// X->half denormal round/pack stage: capture register (S1) then round/pack output register (S2),
// joined by a valid/ready pipe that sustains one result per clock.
module aq_fcnvt_xtoh_rnd
    import aq_vfalu_pkg::*;
(
    input  logic              forever_cpuclk,
    input  logic              cpurst,
    input  logic              xtoh_rnd_flush,
    input  logic              xtoh_rnd_in_vld,
    output logic              xtoh_rnd_in_rdy,
    input  logic              xtoh_rnd_in_sign,
    input  logic [2:0]        xtoh_rnd_in_rm,
    input  logic [10:0]       xtoh_rnd_in_f_v,
    input  logic [FX_W-1:0]   xtoh_rnd_in_f_x,
    input  logic              xtoh_rnd_in_special,
    input  logic [HLEN-1:0]   xtoh_rnd_in_spec_res,
    input  logic [4:0]        xtoh_rnd_in_spec_ff,
    output logic              xtoh_rnd_out_vld,
    input  logic              xtoh_rnd_out_rdy,
    output logic [HLEN-1:0]   xtoh_rnd_out_res,
    output logic [4:0]        xtoh_rnd_out_fflags
);

    logic            s1_vld;
    logic            s2_vld;
    logic            s1_load;
    logic            s2_load;
    xtoh_s1_t        s1_q;
    logic            inc;
    logic [HALF_MAN_W:0] sum;
    logic [HLEN-1:0] res_d;
    logic [4:0]      ff_d;

    // One-level chain: out_rdy reaches in_rdy only through s2_load.
    assign s2_load         = ~s2_vld | xtoh_rnd_out_rdy;
    assign s1_load         = ~s1_vld | s2_load;
    assign xtoh_rnd_in_rdy = s1_load;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst || xtoh_rnd_flush) begin
            s1_vld <= 1'b0;
        end else if (s1_load) begin
            s1_vld <= xtoh_rnd_in_vld;
        end
    end

    // NOTE: payload registers carry no reset; the valid bit alone says whether their contents matter.
    always_ff @(posedge forever_cpuclk) begin
        if (s1_load && xtoh_rnd_in_vld && !xtoh_rnd_flush) begin
            s1_q.sign     <= xtoh_rnd_in_sign;
            s1_q.rm       <= xtoh_rnd_in_rm;
            s1_q.man      <= xtoh_rnd_in_f_v[HALF_MAN_W-1:0];
            s1_q.guard    <= xtoh_rnd_in_f_x[FX_W-1];
            s1_q.sticky   <= |xtoh_rnd_in_f_x[FX_W-2:0];
            s1_q.special  <= xtoh_rnd_in_special;
            s1_q.spec_res <= xtoh_rnd_in_spec_res;
            s1_q.spec_ff  <= xtoh_rnd_in_spec_ff;
        end
    end

    aq_fcnvt_xtoh_rnd_inc u_inc (
        .rm     (s1_q.rm),
        .sign   (s1_q.sign),
        .lsb    (s1_q.man[0]),
        .guard  (s1_q.guard),
        .sticky (s1_q.sticky),
        .inc    (inc)
    );

    assign sum = {1'b0, s1_q.man} + {{HALF_MAN_W{1'b0}}, inc};

    always_comb begin
        res_d = {s1_q.sign, {HALF_EXP_W{1'b0}}, sum[HALF_MAN_W-1:0]};
        ff_d  = 5'h00;
        if (s1_q.special) begin
            res_d = s1_q.spec_res;
            ff_d  = s1_q.spec_ff;
        end else begin
            // Mantissa carry-out rounds the denormal up to the smallest normal.
            if (sum[HALF_MAN_W]) begin
                res_d = {s1_q.sign, {{(HALF_EXP_W-1){1'b0}}, 1'b1}, {HALF_MAN_W{1'b0}}};
            end
            ff_d[FFLAG_NX] = s1_q.guard | s1_q.sticky;
            ff_d[FFLAG_UF] = (s1_q.guard | s1_q.sticky) & ~sum[HALF_MAN_W];
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            s2_vld              <= 1'b0;
            xtoh_rnd_out_res    <= '0;
            xtoh_rnd_out_fflags <= '0;
        end else if (xtoh_rnd_flush) begin
            s2_vld <= 1'b0;
        end else if (s2_load) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                xtoh_rnd_out_res    <= res_d;
                xtoh_rnd_out_fflags <= ff_d;
            end
        end
    end

    assign xtoh_rnd_out_vld = s2_vld;

endmodule

// File: tb/tb_aq_fcnvt_xtoh_rnd.sv
// Directed bench for the X->half round/pack stage: rounding vectors, latency, stalls, flush and reset.
module tb_aq_fcnvt_xtoh_rnd;

    logic        forever_cpuclk = 1'b0;
    logic        cpurst;
    logic        xtoh_rnd_flush;
    logic        xtoh_rnd_in_vld;
    logic        xtoh_rnd_in_rdy;
    logic        xtoh_rnd_in_sign;
    logic [2:0]  xtoh_rnd_in_rm;
    logic [10:0] xtoh_rnd_in_f_v;
    logic [53:0] xtoh_rnd_in_f_x;
    logic        xtoh_rnd_in_special;
    logic [15:0] xtoh_rnd_in_spec_res;
    logic [4:0]  xtoh_rnd_in_spec_ff;
    logic        xtoh_rnd_out_vld;
    logic        xtoh_rnd_out_rdy;
    logic [15:0] xtoh_rnd_out_res;
    logic [4:0]  xtoh_rnd_out_fflags;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic        sign;
        logic [2:0]  rm;
        logic [10:0] fv;
        logic [53:0] fx;
        logic        sp;
        logic [15:0] sres;
        logic [4:0]  sff;
        logic [15:0] eres;
        logic [4:0]  eff;
    } vec_t;

    vec_t        vecs[$];
    logic [20:0] got[$];

    aq_fcnvt_xtoh_rnd dut (
        .forever_cpuclk       (forever_cpuclk),
        .cpurst               (cpurst),
        .xtoh_rnd_flush       (xtoh_rnd_flush),
        .xtoh_rnd_in_vld      (xtoh_rnd_in_vld),
        .xtoh_rnd_in_rdy      (xtoh_rnd_in_rdy),
        .xtoh_rnd_in_sign     (xtoh_rnd_in_sign),
        .xtoh_rnd_in_rm       (xtoh_rnd_in_rm),
        .xtoh_rnd_in_f_v      (xtoh_rnd_in_f_v),
        .xtoh_rnd_in_f_x      (xtoh_rnd_in_f_x),
        .xtoh_rnd_in_special  (xtoh_rnd_in_special),
        .xtoh_rnd_in_spec_res (xtoh_rnd_in_spec_res),
        .xtoh_rnd_in_spec_ff  (xtoh_rnd_in_spec_ff),
        .xtoh_rnd_out_vld     (xtoh_rnd_out_vld),
        .xtoh_rnd_out_rdy     (xtoh_rnd_out_rdy),
        .xtoh_rnd_out_res     (xtoh_rnd_out_res),
        .xtoh_rnd_out_fflags  (xtoh_rnd_out_fflags)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    // Record every result the downstream consumer actually takes at the next rising edge.
    always @(negedge forever_cpuclk) begin
        if (!cpurst && !xtoh_rnd_flush && xtoh_rnd_out_vld && xtoh_rnd_out_rdy)
            got.push_back({xtoh_rnd_out_res, xtoh_rnd_out_fflags});
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic drive(input vec_t v);
        xtoh_rnd_in_sign     = v.sign;
        xtoh_rnd_in_rm       = v.rm;
        xtoh_rnd_in_f_v      = v.fv;
        xtoh_rnd_in_f_x      = v.fx;
        xtoh_rnd_in_special  = v.sp;
        xtoh_rnd_in_spec_res = v.sres;
        xtoh_rnd_in_spec_ff  = v.sff;
    endtask

    // Single op into an empty pipe: checks acceptance, 2-cycle latency and the packed result.
    task automatic send_one(input vec_t v);
        xtoh_rnd_out_rdy = 1'b1;
        drive(v);
        xtoh_rnd_in_vld = 1'b1;
        @(negedge forever_cpuclk);
        check({v.tag, "_in_rdy"}, 32'(xtoh_rnd_in_rdy), 32'd1);
        @(posedge forever_cpuclk); #1;
        xtoh_rnd_in_vld = 1'b0;
        @(negedge forever_cpuclk);
        check({v.tag, "_vld_early"}, 32'(xtoh_rnd_out_vld), 32'd0);
        @(posedge forever_cpuclk); #1;
        @(negedge forever_cpuclk);
        check({v.tag, "_vld"}, 32'(xtoh_rnd_out_vld), 32'd1);
        check({v.tag, "_res"}, 32'(xtoh_rnd_out_res), 32'(v.eres));
        check({v.tag, "_ff"}, 32'(xtoh_rnd_out_fflags), 32'(v.eff));
        @(posedge forever_cpuclk); #1;
    endtask

    // Fill both stages with out_rdy low, then offer a third op so the pipe is full with in_vld high.
    task automatic fill_pipe(input vec_t a, input vec_t b, input string tag);
        xtoh_rnd_out_rdy = 1'b0;
        xtoh_rnd_in_vld  = 1'b1;
        drive(a);
        @(posedge forever_cpuclk); #1;
        drive(b);
        @(posedge forever_cpuclk); #1;
        drive(a);
        @(negedge forever_cpuclk);
        check({tag, "_full_vld"}, 32'(xtoh_rnd_out_vld), 32'd1);
        check({tag, "_full_rdy"}, 32'(xtoh_rnd_in_rdy), 32'd0);
    endtask

    initial begin
        int i;
        int n_got;
        logic [20:0] exp_q[$];

        cpurst = 1'b1;
        xtoh_rnd_flush = 1'b0;
        xtoh_rnd_in_vld = 1'b0;
        xtoh_rnd_out_rdy = 1'b1;
        drive('{"idle", 1'b0, 3'd0, 11'h0, 54'h0, 1'b0, 16'h0, 5'h0, 16'h0, 5'h0});

        //          tag         sgn  rm      f_v     f_x                        sp   sres     sff    eres     eff
        vecs.push_back('{"rne_tie_even", 1'b0, 3'b000, 11'h200, 54'h20_0000_0000_0000, 1'b0, 16'h0, 5'h0, 16'h0200, 5'h03});
        vecs.push_back('{"rne_carry",    1'b0, 3'b000, 11'h3FF, 54'h20_0000_0000_0000, 1'b0, 16'h0, 5'h0, 16'h0400, 5'h01});
        vecs.push_back('{"rdn_neg",      1'b1, 3'b010, 11'h000, 54'h1,                  1'b0, 16'h0, 5'h0, 16'h8001, 5'h03});
        vecs.push_back('{"rup_neg",      1'b1, 3'b011, 11'h000, 54'h1,                  1'b0, 16'h0, 5'h0, 16'h8000, 5'h03});
        vecs.push_back('{"rmm_neg",      1'b1, 3'b100, 11'h000, 54'h1,                  1'b0, 16'h0, 5'h0, 16'h8000, 5'h03});
        vecs.push_back('{"special",      1'b0, 3'b011, 11'h3FF, 54'h3F_FFFF_FFFF_FFFF, 1'b1, 16'h7E00, 5'h10, 16'h7E00, 5'h10});
        vecs.push_back('{"rne_tie_odd",  1'b0, 3'b000, 11'h201, 54'h20_0000_0000_0000, 1'b0, 16'h0, 5'h0, 16'h0202, 5'h03});
        vecs.push_back('{"rtz_guard",    1'b0, 3'b001, 11'h3FF, 54'h30_0000_0000_0000, 1'b0, 16'h0, 5'h0, 16'h03FF, 5'h03});
        vecs.push_back('{"exact",        1'b0, 3'b000, 11'h155, 54'h0,                  1'b0, 16'h0, 5'h0, 16'h0155, 5'h00});
        vecs.push_back('{"rm_reserved",  1'b0, 3'b101, 11'h3FF, 54'h20_0000_0000_0001, 1'b0, 16'h0, 5'h0, 16'h03FF, 5'h03});
        vecs.push_back('{"rup_pos",      1'b0, 3'b011, 11'h3FF, 54'h1,                  1'b0, 16'h0, 5'h0, 16'h0400, 5'h01});
        vecs.push_back('{"rne_neg_carry",1'b1, 3'b000, 11'h3FF, 54'h20_0000_0000_0001, 1'b0, 16'h0, 5'h0, 16'h8400, 5'h01});
        vecs.push_back('{"rdn_pos",      1'b0, 3'b010, 11'h0FF, 54'h3F_0000_0000_0000, 1'b0, 16'h0, 5'h0, 16'h00FF, 5'h03});

        repeat (2) @(posedge forever_cpuclk);
        #1 cpurst = 1'b0;
        @(negedge forever_cpuclk);
        check("rst_out_vld", 32'(xtoh_rnd_out_vld), 32'd0);
        check("rst_out_res", 32'(xtoh_rnd_out_res), 32'd0);
        check("rst_out_ff", 32'(xtoh_rnd_out_fflags), 32'd0);
        check("rst_in_rdy", 32'(xtoh_rnd_in_rdy), 32'd1);
        @(posedge forever_cpuclk); #1;

        foreach (vecs[k]) send_one(vecs[k]);

        // Back-to-back with a 3-cycle downstream stall at the start.
        got.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back({vecs[k].eres, vecs[k].eff});
        i = 0;
        for (int c = 0; c < 40 && i < 4; c++) begin
            drive(vecs[i]);
            xtoh_rnd_in_vld  = 1'b1;
            xtoh_rnd_out_rdy = (c >= 3);
            @(negedge forever_cpuclk);
            if (c == 2) begin
                check("b2b_accepted", 32'(i), 32'd2);
                check("b2b_in_rdy_stall", 32'(xtoh_rnd_in_rdy), 32'd0);
                check("b2b_hold_res", 32'(xtoh_rnd_out_res), 32'(vecs[0].eres));
            end
            if (xtoh_rnd_in_rdy) i++;
            @(posedge forever_cpuclk); #1;
        end
        xtoh_rnd_in_vld  = 1'b0;
        xtoh_rnd_out_rdy = 1'b1;
        for (int k = 0; k < 20 && got.size() < 4; k++) @(posedge forever_cpuclk);
        #1;
        check("b2b_count", 32'(got.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < got.size()) check($sformatf("b2b_order%0d", k), 32'(got[k]), 32'(exp_q[k]));
            else check($sformatf("b2b_missing%0d", k), 32'd0, 32'd1);
        end

        // Flush with both stages full and an input offered: nothing may emerge.
        got.delete();
        fill_pipe(vecs[0], vecs[1], "flush");
        @(posedge forever_cpuclk); #1;
        xtoh_rnd_flush = 1'b1;
        @(posedge forever_cpuclk); #1;
        xtoh_rnd_flush  = 1'b0;
        xtoh_rnd_in_vld = 1'b0;
        @(negedge forever_cpuclk);
        check("flush_out_vld", 32'(xtoh_rnd_out_vld), 32'd0);
        check("flush_in_rdy", 32'(xtoh_rnd_in_rdy), 32'd1);
        xtoh_rnd_out_rdy = 1'b1;
        repeat (4) @(posedge forever_cpuclk);
        #1;
        check("flush_emitted", 32'(got.size()), 32'd0);

        // Reset pulse mid-operation: same drop behaviour plus cleared output data.
        got.delete();
        fill_pipe(vecs[2], vecs[5], "rst");
        @(posedge forever_cpuclk); #1;
        cpurst = 1'b1;
        @(posedge forever_cpuclk); #1;
        cpurst = 1'b0;
        xtoh_rnd_in_vld = 1'b0;
        @(negedge forever_cpuclk);
        check("rst2_out_vld", 32'(xtoh_rnd_out_vld), 32'd0);
        check("rst2_out_res", 32'(xtoh_rnd_out_res), 32'd0);
        check("rst2_out_ff", 32'(xtoh_rnd_out_fflags), 32'd0);
        xtoh_rnd_out_rdy = 1'b1;
        repeat (4) @(posedge forever_cpuclk);
        #1;
        n_got = got.size();
        check("rst2_emitted", 32'(n_got), 32'd0);

        // Pipe must still work normally after the flush and reset.
        send_one(vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
